// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared MVU constants and address-generator state encodings
package mvu_pkg;

    localparam int AGU_BWADDR   = 21;
    localparam int AGU_BWLENGTH = 8;
    localparam int AGU_NDIM     = 5;

    typedef enum logic [1:0] {
        AGU_IDLE = 2'd0,
        AGU_RUN  = 2'd1,
        AGU_DONE = 2'd2
    } agu_state_e;

endpackage

// File: rtl/agu_nd_if.sv
// rtl/agu_nd_if.sv - address stream bundle of the N-dimensional address generator
interface agu_nd_if
    import mvu_pkg::*;
#(
    parameter int BWADDR = AGU_BWADDR,
    parameter int NDIM   = AGU_NDIM
);
    logic              addr_valid;
    logic              addr_ready;
    logic [BWADDR-1:0] addr_out;
    logic [NDIM-2:0]   z_out;
    logic [NDIM-1:0]   on_j;

    modport master (output addr_valid, output addr_out, output z_out, output on_j, input addr_ready);
    modport slave  (input addr_valid, input addr_out, input z_out, input on_j, output addr_ready);
endinterface

// File: rtl/agu_dimctr.sv
// rtl/agu_dimctr.sv - one per-dimension down counter with reload and zero flag
module agu_dimctr
    import mvu_pkg::*;
#(
    parameter int BWLENGTH = AGU_BWLENGTH
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                i_load,
    input  logic                i_dec,
    input  logic [BWLENGTH-1:0] i_len,
    output logic                o_zero
);
    logic [BWLENGTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/agu_nd.sv
// rtl/agu_nd.sv - N-dimensional strided address generator with valid/ready output
module agu_nd
    import mvu_pkg::*;
#(
    parameter int BWADDR   = AGU_BWADDR,
    parameter int BWLENGTH = AGU_BWLENGTH,
    parameter int NDIM     = AGU_NDIM
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         mode,
    input  logic [BWADDR-1:0]            base,
    input  logic [(NDIM-1)*BWLENGTH-1:0] l,
    input  logic [NDIM*BWADDR-1:0]       j,
    input  logic                         addr_ready,
    output logic                         addr_valid,
    output logic [BWADDR-1:0]            addr_out,
    output logic [NDIM-2:0]              z_out,
    output logic [NDIM-1:0]              on_j,
    output logic                         busy,
    output logic                         done
);
    localparam int NC = NDIM - 1;
    localparam int MW = $clog2(NDIM);

    agu_state_e                 r_state;
    agu_state_e                 w_state_nxt;
    logic                       r_mode;
    logic [NC*BWLENGTH-1:0]     r_l;
    logic [NDIM*BWADDR-1:0]     r_j;
    logic [BWADDR-1:0]          r_addr;
    logic                       w_hs;
    logic                       w_last;
    logic [MW-1:0]              w_m;
    logic [NC-1:0]              w_zero;
    logic [NC-1:0]              w_load;
    logic [NC-1:0]              w_dec;
    logic [BWADDR-1:0]          w_jump;

    assign addr_valid = (r_state == AGU_RUN);
    assign busy       = (r_state == AGU_RUN);
    assign done       = (r_state == AGU_DONE);
    assign addr_out   = r_addr;
    assign w_hs       = addr_valid & addr_ready;
    assign w_last     = (w_m == MW'(NC));
    assign z_out      = {NC{w_hs}} & w_zero;

    // Jump level = index of the first non-zero counter, NC when every counter is exhausted
    always_comb begin
        w_m = MW'(NC);
        for (int k = NC - 1; k >= 0; k--) begin
            if (!w_zero[k]) begin
                w_m = MW'(k);
            end
        end
    end

    always_comb begin
        w_jump = '0;
        on_j   = '0;
        for (int k = 0; k < NDIM; k++) begin
            if (w_m == MW'(k)) begin
                w_jump  = r_j[k*BWADDR +: BWADDR];
                on_j[k] = w_hs;
            end
        end
    end

    // Start loads straight from the inputs so the first address needs no extra cycle
    for (genvar g = 0; g < NC; g++) begin : g_ctr
        assign w_load[g] = start | (w_hs & (MW'(g) < w_m));
        assign w_dec[g]  = w_hs & (w_m == MW'(g));

        agu_dimctr #(
            .BWLENGTH (BWLENGTH)
        ) u_ctr (
            .clk    (clk),
            .clr    (clr),
            .i_load (w_load[g]),
            .i_dec  (w_dec[g]),
            .i_len  (start ? l[g*BWLENGTH +: BWLENGTH] : r_l[g*BWLENGTH +: BWLENGTH]),
            .o_zero (w_zero[g])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= AGU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = AGU_RUN;
        end else if (r_state == AGU_RUN && w_hs && w_last && !r_mode) begin
            w_state_nxt = AGU_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_addr <= '0;
            r_mode <= 1'b0;
            r_l    <= '0;
            r_j    <= '0;
        end else if (start) begin
            r_addr <= base;
            r_mode <= mode;
            r_l    <= l;
            r_j    <= j;
        end else if (w_hs && !(w_last && !r_mode)) begin
            r_addr <= r_addr + w_jump;
        end
    end
endmodule
